// File: rtl/instrumented_adder_meas.sv
// Measurement controller for the instrumented adder: loads operands and path
// masks, enables the ring oscillator for a programmed window, counts its edges.
module instrumented_adder_meas #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 32,
  parameter int WIN_W       = 16,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             active,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] ext_sel_b_in,
  input  logic [WIDTH-1:0] ring_sel_b_in,
  input  logic             chain_out,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] ext_bit_b,
  output logic [WIDTH-1:0] ring_bit_b,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] sum_capture,
  output logic             overflow
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [SET_W-1:0]       settle_cnt;
  logic [WIN_W-1:0]       win_len_q;
  logic [WIN_W-1:0]       win_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       edge_cnt_nxt;
  logic                   sat_hit;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_prev;
  logic                   chain_rise;

  // chain_out is asynchronous to wb_clk_i; edges are detected after the sync chain
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q    <= '0;
      edge_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], chain_out};
      edge_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign chain_rise = sync_q[SYNC_STAGES-1] & ~edge_prev;

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    sat_hit      = 1'b0;
    if (state == ST_RUN && chain_rise) begin
      if (edge_cnt == '1) begin
        sat_hit = 1'b1;
      end else begin
        edge_cnt_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  // count/sum_capture load on the edge entering DONE so they are valid with done
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      win_len_q   <= '0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      a_out       <= '0;
      b_out       <= '0;
      ext_bit_b   <= '1;
      ring_bit_b  <= '1;
      ring_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      sum_capture <= '0;
      overflow    <= 1'b0;
    end else if (state != ST_IDLE && !active) begin
      state   <= ST_IDLE;
      ring_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && active) begin
            a_out      <= a_in;
            b_out      <= b_in;
            ext_bit_b  <= ext_sel_b_in;
            ring_bit_b <= ring_sel_b_in;
            win_len_q  <= window_len;
            settle_cnt <= SET_W'(SETTLE - 1);
            edge_cnt   <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            if (win_len_q != '0) begin
              win_cnt <= win_len_q - WIN_W'(1);
              ring_en <= 1'b1;
              state   <= ST_RUN;
            end else begin
              count       <= edge_cnt;
              sum_capture <= sum_in;
              done        <= 1'b1;
              state       <= ST_DONE;
            end
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        ST_RUN: begin
          edge_cnt <= edge_cnt_nxt;
          if (sat_hit) begin
            overflow <= 1'b1;
          end
          if (win_cnt == '0) begin
            ring_en     <= 1'b0;
            count       <= edge_cnt_nxt;
            sum_capture <= sum_in;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instrumented_adder_meas.md
Name: instrumented_adder_meas

Overview:
Parametrised measurement controller for the instrumented adder. It loads operands and path-select masks into the adder and enables its ring oscillator for a programmable window of wb_clk_i cycles. It counts rising edges of the asynchronous chain_out, captures the settled sum, and reports a saturating count. It sits between the LA/IO capture logic and the instrumented adder macro inside the wrapper. It replaces fixed free-running operation with start/done handshaked, repeatable measurements.

Parameters:
WIDTH, 32, adder operand/sum width
CNT_W, 32, edge counter width
WIN_W, 16, window length register width
SETTLE, 4, wb_clk_i cycles that operands settle before the ring is enabled (>=1)
SYNC_STAGES, 2, synchroniser depth on chain_out (>=2)

Ports:
wb_clk_i  in  1  system clock
wb_rst_n  in  1  asynchronous active-low reset
active  in  1  wrapper enable; low aborts any measurement
start  in  1  single-cycle request; sampled only in IDLE
window_len  in  WIN_W  ring-enable window in wb_clk_i cycles; sampled on accepted start
a_in  in  WIDTH  operand A; sampled on accepted start
b_in  in  WIDTH  operand B; sampled on accepted start
ext_sel_b_in  in  WIDTH  external-bit select mask (active low); sampled on accepted start
ring_sel_b_in  in  WIDTH  ring-bit select mask (active low); sampled on accepted start
chain_out  in  1  ring oscillator output from the adder; asynchronous
sum_in  in  WIDTH  adder sum output
a_out  out  WIDTH  registered operand A to the adder
b_out  out  WIDTH  registered operand B to the adder
ext_bit_b  out  WIDTH  registered external-bit mask
ring_bit_b  out  WIDTH  registered ring-bit mask
ring_en  out  1  ring oscillator enable
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when results are valid
count  out  CNT_W  chain_out rising edges counted in the last completed window
sum_capture  out  WIDTH  sum_in sampled at completion
overflow  out  1  sticky; the counter saturated during the last window

Behaviour:
- Reset (wb_rst_n low, asynchronous): all outputs 0, except ext_bit_b and ring_bit_b, which are all-ones (paths deselected). FSM goes to IDLE. Synchroniser flops are cleared.
- States: IDLE, SETTLE, RUN, DONE.
- IDLE:
  - On start=1 with active=1, register a/b/masks/window_len.
  - Clear the internal counter and overflow.
  - Go to SETTLE.
  - start with active=0 is ignored.
- SETTLE:
  - ring_en=0.
  - Stay exactly SETTLE cycles.
  - Then go to RUN if window_len!=0, otherwise go directly to DONE.
- RUN:
  - ring_en=1 for exactly window_len cycles. ring_en rises on the first RUN cycle.
  - Each cycle, a rising edge on the synchronised chain_out (last stage 1, previous-stage sample 0) increments the counter.
  - Edges are counted only while in RUN. Edges still in the synchroniser pipe at window end are discarded.
  - On the last RUN cycle, go to DONE; ring_en is 0 in DONE.
- DONE:
  - One cycle.
  - count <= counter, sum_capture <= sum_in, done=1.
  - Next state is IDLE.
  - count and sum_capture hold until the next DONE.
- Latency from start to done = 1 + SETTLE + window_len cycles. With SETTLE=4 and window_len=10, done is asserted 15 cycles after the start cycle.
- Saturation: the counter stops at 2^CNT_W-1 and sets overflow. overflow stays high until the next accepted start.
- start while busy: ignored; the operand registers are unchanged.
- active falls in any non-IDLE state:
  - Next cycle the FSM is in IDLE and ring_en=0.
  - No done pulse.
  - count, sum_capture and overflow keep their previous values.
- Reset mid-RUN: ring_en drops immediately (asynchronously); outputs take their reset values.
- Measurement is valid only for chain_out frequency < wb_clk_i/2. Faster rings alias; this is not flagged.
- Operand outputs are driven from registers only; there is no combinational path from the *_in ports.

Test Plan:
- Reset then idle: hold wb_rst_n=0 for 3 cycles, release -> ring_en=0, busy=0, done=0, count=0, ext_bit_b=ring_bit_b=32'hFFFFFFFF.
- Basic window: a_in=5, b_in=7, window_len=10, chain_out toggling at clk/4 -> done 15 cycles after start; count between 2 and 3; sum_capture=12; ring_en high for exactly 10 cycles.
- Zero window: window_len=0, chain_out toggling -> ring_en never high; done 5 cycles after start; count=0; overflow=0.
- Saturation: CNT_W=4, window_len=100, chain_out at clk/4 -> count=15, overflow=1. A following start with window_len=4 clears overflow.
- Abort: drop active 3 cycles into RUN -> ring_en=0 the next cycle; busy=0; no done; count retains the previous result.
- Busy start and async reset: pulse start with a_in=9 during RUN -> a_out unchanged. Assert wb_rst_n=0 mid-RUN -> ring_en=0 in the same cycle without waiting for a clock edge.
